// File: rtl/intack_pkg.sv
// Shared constants and types for the 68000 interrupt-acknowledge responder.
package intack_pkg;

  localparam logic [3:0] ADR_CTRL = 4'd0;
  localparam logic [3:0] ADR_VEC1 = 4'd1;
  localparam logic [3:0] ADR_VEC2 = 4'd2;
  localparam logic [3:0] ADR_VEC3 = 4'd3;
  localparam logic [3:0] ADR_VEC4 = 4'd4;
  localparam logic [3:0] ADR_VEC5 = 4'd5;
  localparam logic [3:0] ADR_VEC6 = 4'd6;
  localparam logic [3:0] ADR_VEC7 = 4'd7;

  localparam logic [7:0] CTRL_RST      = 8'hFE;
  localparam logic [7:0] SPUR_VEC_DFLT = 8'h18;
  localparam logic [7:0] VEC_BASE_DFLT = 8'h40;
  localparam logic [2:0] LEVEL_NONE    = 3'd0;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    LOOKUP   = 2'd2,
    RESPOND  = 2'd3
  } iack_state_t;

endpackage

// File: rtl/intack_regs.sv
// Wishbone register file holding the per-level vectors and autovector enables.
module intack_regs
  import intack_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = VEC_BASE_DFLT
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [3:0]      wb_adr_i,
  input  logic [7:0]      wb_dat_i,
  output logic [7:0]      wb_dat_o,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic [7:1][7:0] vec,
  output logic [7:1]      avec_en
);

  logic            ack_r;
  logic [7:0]      dat_r;
  logic [7:1][7:0] vec_r;
  logic [7:1]      avec_en_r;
  logic            acc_s;
  logic [7:0]      rd_data_s;

  // Access qualifier and read mux; ack_r gating yields a single-cycle ack per access.
  always_comb begin
    acc_s     = wb_stb_i & wb_cyc_i & ~ack_r;
    rd_data_s = 8'h00;
    case (wb_adr_i)
      ADR_CTRL: rd_data_s = {avec_en_r, 1'b0};
      ADR_VEC1, ADR_VEC2, ADR_VEC3, ADR_VEC4,
      ADR_VEC5, ADR_VEC6, ADR_VEC7: rd_data_s = vec_r[wb_adr_i[2:0]];
      default: rd_data_s = 8'h00;
    endcase
  end

  // Register state, ack and read data; writes commit on the edge that raises ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      ack_r     <= 1'b0;
      dat_r     <= 8'h00;
      avec_en_r <= CTRL_RST[7:1];
      for (int i = 1; i <= 7; i++) begin
        vec_r[i] <= VEC_BASE + 8'(i - 1);
      end
    end else begin
      ack_r <= acc_s;
      dat_r <= acc_s ? rd_data_s : 8'h00;
      if (acc_s && wb_we_i) begin
        case (wb_adr_i)
          ADR_CTRL: avec_en_r <= wb_dat_i[7:1];
          ADR_VEC1, ADR_VEC2, ADR_VEC3, ADR_VEC4,
          ADR_VEC5, ADR_VEC6, ADR_VEC7: vec_r[wb_adr_i[2:0]] <= wb_dat_i;
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;
  assign vec      = vec_r;
  assign avec_en  = avec_en_r;

endmodule

// File: rtl/intack_vector.sv
// Answers 68000 IACK cycles with a programmed vector, an autovector request or
// the spurious vector, and pulses a clear back to the acknowledged source.
module intack_vector
  import intack_pkg::*;
#(
  parameter logic [7:0] SPUR_VEC = SPUR_VEC_DFLT,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DFLT
) (
  input  logic       wb_clk_i,
  input  logic       wb_reset_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  input  logic [6:0] int_i,
  input  logic       iack_stb_i,
  input  logic [2:0] iack_level_i,
  output logic [7:0] iack_vec_o,
  output logic       iack_avec_o,
  output logic       iack_ack_o,
  output logic [6:0] int_clr_o
);

  logic [7:1][7:0] vec_s;
  logic [7:1]      avec_en_s;

  iack_state_t state_r;
  logic [2:0]  lvl_r;
  logic [7:0]  vec_r;
  logic        avec_r;
  logic        ack_r;
  logic [6:0]  clr_r;

  logic        hit_s;
  logic [7:0]  sel_vec_s;
  logic        sel_avec_s;
  logic [6:0]  clr_mask_s;

  intack_regs #(
    .VEC_BASE (VEC_BASE)
  ) u_regs (
    .wb_clk_i   (wb_clk_i),
    .wb_reset_i (wb_reset_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_we_i    (wb_we_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_ack_o   (wb_ack_o),
    .vec        (vec_s),
    .avec_en    (avec_en_s)
  );

  // Per-level lookup of request, vector, autovector enable and clear mask for the latched level.
  always_comb begin
    hit_s      = 1'b0;
    sel_vec_s  = 8'h00;
    sel_avec_s = 1'b0;
    clr_mask_s = 7'h00;
    if (lvl_r != LEVEL_NONE) begin
      hit_s      = int_i[lvl_r - 3'd1];
      sel_vec_s  = vec_s[lvl_r];
      sel_avec_s = avec_en_s[lvl_r];
      clr_mask_s = 7'h01 << (lvl_r - 3'd1);
    end else begin
      hit_s      = 1'b0;
      sel_vec_s  = 8'h00;
      sel_avec_s = 1'b0;
      clr_mask_s = 7'h00;
    end
  end

  // IACK state machine; outputs default to 0 so they can only be live in RESPOND.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_r <= WAIT_REL;
      lvl_r   <= 3'd0;
      vec_r   <= 8'h00;
      avec_r  <= 1'b0;
      ack_r   <= 1'b0;
      clr_r   <= 7'h00;
    end else begin
      vec_r  <= 8'h00;
      avec_r <= 1'b0;
      ack_r  <= 1'b0;
      clr_r  <= 7'h00;
      case (state_r)
        WAIT_REL: begin
          if (!iack_stb_i) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          if (iack_stb_i) begin
            lvl_r   <= iack_level_i;
            state_r <= LOOKUP;
          end
        end
        LOOKUP: begin
          state_r <= RESPOND;
          ack_r   <= 1'b1;
          if (!hit_s) begin
            vec_r <= SPUR_VEC;
          end else if (sel_avec_s) begin
            avec_r <= 1'b1;
            clr_r  <= clr_mask_s;
          end else begin
            vec_r <= sel_vec_s;
            clr_r <= clr_mask_s;
          end
        end
        RESPOND: state_r <= WAIT_REL;
        default: state_r <= WAIT_REL;
      endcase
    end
  end

  assign iack_vec_o  = vec_r;
  assign iack_avec_o = avec_r;
  assign iack_ack_o  = ack_r;
  assign int_clr_o   = clr_r;

endmodule

// File: tb/tb_intack_vector.sv
// Directed self-checking bench for intack_vector.
module tb_intack_vector;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] wb_adr;
  logic [7:0] wb_dat_w;
  logic [7:0] wb_dat_r;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_cyc;
  logic       wb_ack;
  logic [6:0] int_lines;
  logic       iack_stb;
  logic [2:0] iack_level;
  logic [7:0] iack_vec;
  logic       iack_avec;
  logic       iack_ack;
  logic [6:0] int_clr;

  int checks = 0;
  int errors = 0;

  intack_vector dut (
    .wb_clk_i     (clk),
    .wb_reset_i   (rst),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_dat_o     (wb_dat_r),
    .wb_we_i      (wb_we),
    .wb_stb_i     (wb_stb),
    .wb_cyc_i     (wb_cyc),
    .wb_ack_o     (wb_ack),
    .int_i        (int_lines),
    .iack_stb_i   (iack_stb),
    .iack_level_i (iack_level),
    .iack_vec_o   (iack_vec),
    .iack_avec_o  (iack_avec),
    .iack_ack_o   (iack_ack),
    .int_clr_o    (int_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic iack_cycle(input logic [2:0] lvl, input logic [6:0] ints,
                            input logic [7:0] exp_vec, input logic exp_avec,
                            input logic [6:0] exp_clr);
    iack_stb = 1'b0;
    tick();
    iack_level = lvl;
    int_lines  = ints;
    iack_stb   = 1'b1;
    tick();
    checks++;
    if (iack_ack !== 1'b0) begin
      errors++; $display("FAIL iack_early_l%0d: got %b expected 0", lvl, iack_ack);
    end
    tick();
    checks++;
    if (iack_ack !== 1'b1 || iack_avec !== exp_avec || int_clr !== exp_clr ||
        (!exp_avec && iack_vec !== exp_vec)) begin
      errors++;
      $display("FAIL iack_resp_l%0d: got ack=%b avec=%b vec=%h clr=%b expected ack=1 avec=%b vec=%h clr=%b",
               lvl, iack_ack, iack_avec, iack_vec, int_clr, exp_avec, exp_vec, exp_clr);
    end
    iack_stb = 1'b0;
    tick();
    checks++;
    if (iack_ack !== 1'b0 || int_clr !== 7'h00) begin
      errors++; $display("FAIL iack_after_l%0d: got ack=%b clr=%b expected 0", lvl, iack_ack, int_clr);
    end
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [7:0] dat);
    wb_adr = adr; wb_dat_w = dat; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    tick();
    checks++;
    if (wb_ack !== 1'b1) begin
      errors++; $display("FAIL wb_write_ack a%0d: got %b expected 1", adr, wb_ack);
    end
    wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [3:0] adr, input logic [7:0] exp);
    wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    checks++;
    if (wb_ack !== 1'b0) begin
      errors++; $display("FAIL wb_read_preack a%0d: got %b expected 0", adr, wb_ack);
    end
    tick();
    checks++;
    if (wb_ack !== 1'b1 || wb_dat_r !== exp) begin
      errors++; $display("FAIL wb_read a%0d: got ack=%b dat=%h expected ack=1 dat=%h", adr, wb_ack, wb_dat_r, exp);
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;
    tick();
    checks++;
    if (wb_ack !== 1'b0 || wb_dat_r !== 8'h00) begin
      errors++; $display("FAIL wb_read_end a%0d: got ack=%b dat=%h expected 0", adr, wb_ack, wb_dat_r);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; iack_stb = 1'b1; iack_level = 3'd3; int_lines = 7'b0000100;
    tick(); tick();
    checks++;
    if (iack_ack !== 1'b0 || iack_avec !== 1'b0 || iack_vec !== 8'h00 || int_clr !== 7'h00 ||
        wb_ack !== 1'b0 || wb_dat_r !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got ack=%b avec=%b vec=%h clr=%b wback=%b wbdat=%h expected all 0",
                         iack_ack, iack_avec, iack_vec, int_clr, wb_ack, wb_dat_r);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (iack_ack !== 1'b0) begin
        errors++; $display("FAIL reset_stb_held c%0d: got %b expected 0", i, iack_ack);
      end
    end
    iack_cycle(3'd3, 7'b0000100, 8'h00, 1'b1, 7'b0000100);
  endtask

  task automatic test_config_read;
    logic [7:0] exp_tab [10];
    exp_tab = '{8'hFE, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h00, 8'h00};
    for (int a = 0; a < 10; a++) begin
      wb_read(4'(a), exp_tab[a]);
    end
    wb_write(4'd9, 8'hAA);
    wb_read(4'd9, 8'h00);
  endtask

  task automatic test_program_vector;
    wb_write(4'd0, 8'h00);
    wb_write(4'd5, 8'h64);
    wb_read(4'd0, 8'h00);
    wb_read(4'd5, 8'h64);
    iack_cycle(3'd5, 7'b0010000, 8'h64, 1'b0, 7'b0010000);
    iack_cycle(3'd7, 7'b1000000, 8'h46, 1'b0, 7'b1000000);
  endtask

  task automatic test_level_latch;
    iack_stb = 1'b0;
    tick();
    iack_level = 3'd5; int_lines = 7'b0010000; iack_stb = 1'b1;
    tick();
    iack_level = 3'd6;
    tick();
    checks++;
    if (iack_ack !== 1'b1 || iack_vec !== 8'h64 || int_clr !== 7'b0010000) begin
      errors++; $display("FAIL level_latch: got ack=%b vec=%h clr=%b expected ack=1 vec=64 clr=0010000",
                         iack_ack, iack_vec, int_clr);
    end
    iack_stb = 1'b0;
    tick();
  endtask

  task automatic test_spurious;
    iack_cycle(3'd6, 7'b0000000, 8'h18, 1'b0, 7'h00);
    iack_cycle(3'd0, 7'b1111111, 8'h18, 1'b0, 7'h00);
    iack_cycle(3'd4, 7'b1110111, 8'h18, 1'b0, 7'h00);
  endtask

  task automatic test_back_to_back;
    iack_stb = 1'b0;
    tick();
    iack_level = 3'd2; int_lines = 7'b0000010; iack_stb = 1'b1;
    tick();
    wb_adr = 4'd2; wb_dat_w = 8'h80; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    tick();
    checks++;
    if (iack_ack !== 1'b1 || iack_vec !== 8'h41 || int_clr !== 7'b0000010 || wb_ack !== 1'b1) begin
      errors++; $display("FAIL write_collision: got ack=%b vec=%h clr=%b wback=%b expected ack=1 vec=41 clr=0000010 wback=1",
                         iack_ack, iack_vec, int_clr, wb_ack);
    end
    wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0; iack_stb = 1'b0;
    tick();
    iack_cycle(3'd2, 7'b0000010, 8'h80, 1'b0, 7'b0000010);
  endtask

  task automatic test_reset_in_respond;
    iack_stb = 1'b0;
    tick();
    iack_level = 3'd1; int_lines = 7'b0000001; iack_stb = 1'b1;
    tick(); tick();
    checks++;
    if (iack_ack !== 1'b1 || int_clr !== 7'b0000001) begin
      errors++; $display("FAIL respond_before_reset: got ack=%b clr=%b expected ack=1 clr=0000001", iack_ack, int_clr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (iack_ack !== 1'b0 || int_clr !== 7'h00) begin
      errors++; $display("FAIL reset_in_respond: got ack=%b clr=%b expected 0", iack_ack, int_clr);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (iack_ack !== 1'b0 || int_clr !== 7'h00) begin
        errors++; $display("FAIL no_resp_after_reset c%0d: got ack=%b clr=%b expected 0", i, iack_ack, int_clr);
      end
    end
    iack_cycle(3'd1, 7'b0000001, 8'h00, 1'b1, 7'b0000001);
  endtask

  initial begin
    rst = 1'b1; wb_adr = 4'd0; wb_dat_w = 8'h00; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    int_lines = 7'h00; iack_stb = 1'b0; iack_level = 3'd0;
    test_reset();
    test_config_read();
    test_program_vector();
    test_level_latch();
    test_spurious();
    test_back_to_back();
    test_reset_in_respond();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
